writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Final pipeline stage. Consumes MW_* from the memory stage and writes the
//   64-entry register file (ids 0-31 integer x0-x31, ids 32-63 float f0-f31).
//   Provides two synchronous read ports to decode, with write bypass, and
//   counts retired instructions (instret). After reset, a clear sequencer
//   zeroes the RAM-based register file and stalls the pipe while it runs.
// PARAMETERS
//   NREGS      64  register file depth; must be a power of 2, max 64
//   CNT_WIDTH  64  retired-instruction counter width
// PORTS
//   clk_i          in   1   clock; all state changes on rising edge
//   reset_i        in   1   reset; asynchronous, active-high
//   MW_PC_i        in   32  retiring PC
//   MW_instr_i     in   32  retiring instruction
//   MW_nop_i       in   1   1 = bubble; no write, no retire
//   MW_rdId_i      in   6   destination register id
//   MW_wbData_i    in   32  writeback data
//   MW_wbEnable_i  in   1   register write request
//   DW_rs1Id_i     in   6   read port 1 address
//   DW_rs2Id_i     in   6   read port 2 address
//   DW_rs1_o       out  32  read port 1 data; registered
//   DW_rs2_o       out  32  read port 2 data; registered
//   WB_busy_o      out  1   1 = clear in progress; upstream holds fetch/decode
//   WB_instret_o   out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//   Reset values (async): state=CLEAR, clrIdx=0, DW_rs1_o=DW_rs2_o=0,
//     WB_busy_o=1, WB_instret_o=0. Register-file RAM has no reset.
//   FSM, 2 states:
//     CLEAR: each cycle writes 0 to reg[clrIdx], then clrIdx++. When
//       clrIdx==NREGS-1 is written, next state is RUN. Duration: NREGS cycles.
//       WB_busy_o=1. MW writes are ignored, instret is frozen, and read
//       outputs register 0.
//     RUN: WB_busy_o=0. Stays in RUN until reset.
//   Reset asserted mid-CLEAR or mid-RUN: returns to CLEAR, clrIdx=0, and the
//     full clear sequence repeats.
//   Write (RUN only): we = MW_wbEnable_i & ~MW_nop_i & (MW_rdId_i != 0).
//     On the rising edge, reg[MW_rdId_i] <= MW_wbData_i.
//   Read ports:
//     Latency 1 cycle. DW_rsN_o at edge t+1 reflects DW_rsNId_i at edge t.
//     Id 0 always reads 0. Id 32 (f0) is an ordinary register.
//     Bypass: if we is asserted in the same cycle and DW_rsNId_i==MW_rdId_i,
//       DW_rsN_o <= MW_wbData_i (new data, not stale RAM data).
//     Both ports may address the same register; each output is independent.
//   Retire: in RUN, if ~MW_nop_i then WB_instret_o <= WB_instret_o + 1,
//     independent of MW_wbEnable_i (stores and branches retire too).
//     Wraps from all-ones to 0 with no flag.
//   MW_PC_i and MW_instr_i are used only by the trace feature.
// CONFIGURATION
//   Macro WB_TRACE_EN:
//   Defined: adds output ports
//     trace_valid_o (1), trace_pc_o (32), trace_instr_o (32),
//     trace_rdId_o (6), trace_wdata_o (32), trace_we_o (1).
//     These register the retiring instruction 1 cycle after retire:
//       trace_valid_o = RUN & ~MW_nop_i
//       trace_we_o    = we
//       trace_wdata_o = MW_wbData_i when we, else 0
//     Reset value of all trace outputs is 0.
//   Undefined: the trace ports and their logic are absent; all other
//     behaviour is identical.
// TESTING
//   T1 Reset, then hold MW_nop_i=1: WB_busy_o=1 for exactly 64 cycles, then 0.
//      Afterwards every id 0-63 reads 0, and WB_instret_o=0.
//   T2 In RUN, write id 5=0xDEADBEEF (we=1). Next cycle read rs1Id=5:
//      DW_rs1_o=0xDEADBEEF one cycle later.
//      Write id 0=0x1234, then read id 0: reads 0.
//   T3 Write id 40=0xA5A5A5A5 while rs1Id=rs2Id=40 in the same cycle:
//      both outputs=0xA5A5A5A5 next cycle (bypass).
//      Repeat with MW_nop_i=1: outputs show the old value.
//   T4 Retire 10 non-nop instructions (3 with wbEnable=0) mixed with
//      5 bubbles: WB_instret_o=10.
//      Preload the counter to all-ones via force, retire 1: reads 0.
//   T5 Assert reset_i async at clrIdx=30 of CLEAR, and again 100 cycles
//      into RUN: outputs 0 immediately, WB_busy_o=1, then a full
//      64-cycle clear.
//      Register written before the 2nd reset reads 0 afterwards.
//   T6 (WB_TRACE_EN) Retire PC=0x100, instr=0x00A00293, rd=5, data=10:
//      next cycle trace_valid_o=1 with these values and trace_we_o=1.
//      A bubble gives trace_valid_o=0.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage -- register-file writeback, bypassed read ports,
// post-reset RAM clear sequencer and retire counter. Optional trace outputs under `WB_TRACE_EN.
module writeback_unit #(
   parameter int NREGS     = 64,
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [31:0]          MW_PC_i,
   input  logic [31:0]          MW_instr_i,
   input  logic                 MW_nop_i,
   input  logic [5:0]           MW_rdId_i,
   input  logic [31:0]          MW_wbData_i,
   input  logic                 MW_wbEnable_i,
   input  logic [5:0]           DW_rs1Id_i,
   input  logic [5:0]           DW_rs2Id_i,
   output logic [31:0]          DW_rs1_o,
   output logic [31:0]          DW_rs2_o,
   output logic                 WB_busy_o,
`ifdef WB_TRACE_EN
   output logic                 trace_valid_o,
   output logic [31:0]          trace_pc_o,
   output logic [31:0]          trace_instr_o,
   output logic [5:0]           trace_rdId_o,
   output logic [31:0]          trace_wdata_o,
   output logic                 trace_we_o,
`endif
   output logic [CNT_WIDTH-1:0] WB_instret_o
);

   localparam int            AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;

   logic [0:0]           r_state;
   logic [AW-1:0]        r_clrIdx;
   logic [31:0]          r_rf [NREGS];
   logic [31:0]          r_rs1;
   logic [31:0]          r_rs2;
   logic [CNT_WIDTH-1:0] r_instret;

   logic          w_run;
   logic          w_we;
   logic          w_ramWe;
   logic [AW-1:0] w_ramAddr;
   logic [31:0]   w_ramData;

   assign w_run = (r_state == S_RUN);
   assign w_we  = w_run & MW_wbEnable_i & ~MW_nop_i & (MW_rdId_i != 6'd0);

   // Clear sequencer: one RAM entry per cycle, then RUN until the next reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state  <= S_CLEAR;
         r_clrIdx <= '0;
      end else if (r_state == S_CLEAR) begin
         r_clrIdx <= r_clrIdx + AW'(1);
         if (r_clrIdx == LAST_IDX)
            r_state <= S_RUN;
      end
   end

   // Single RAM write port shared between the clear sequencer and writeback.
   assign w_ramWe   = ~w_run | w_we;
   assign w_ramAddr = w_run ? MW_rdId_i[AW-1:0] : r_clrIdx;
   assign w_ramData = w_run ? MW_wbData_i : 32'd0;

   always_ff @(posedge clk_i) begin
      if (w_ramWe)
         r_rf[w_ramAddr] <= w_ramData;
   end

   // Read data for one port: x0 is hardwired, same-cycle writes are forwarded.
   function automatic logic [31:0] f_read(input logic [5:0] id);
      logic [31:0] v;
      v = 32'd0;
      if (w_run && id != 6'd0) begin
         if (w_we && id == MW_rdId_i)
            v = MW_wbData_i;
         else
            v = r_rf[id[AW-1:0]];
      end
      return v;
   endfunction

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rs1 <= '0;
         r_rs2 <= '0;
      end else begin
         r_rs1 <= f_read(DW_rs1Id_i);
         r_rs2 <= f_read(DW_rs2Id_i);
      end
   end

   // Every non-bubble retires, whether or not it writes a register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_instret <= '0;
      else if (w_run && !MW_nop_i)
         r_instret <= r_instret + CNT_WIDTH'(1);
   end

   assign DW_rs1_o     = r_rs1;
   assign DW_rs2_o     = r_rs2;
   assign WB_busy_o    = ~w_run;
   assign WB_instret_o = r_instret;

`ifdef WB_TRACE_EN
   logic        r_tValid;
   logic [31:0] r_tPc;
   logic [31:0] r_tInstr;
   logic [5:0]  r_tRdId;
   logic [31:0] r_tWdata;
   logic        r_tWe;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tValid <= 1'b0;
         r_tPc    <= '0;
         r_tInstr <= '0;
         r_tRdId  <= '0;
         r_tWdata <= '0;
         r_tWe    <= 1'b0;
      end else begin
         r_tValid <= w_run & ~MW_nop_i;
         r_tPc    <= MW_PC_i;
         r_tInstr <= MW_instr_i;
         r_tRdId  <= MW_rdId_i;
         r_tWdata <= w_we ? MW_wbData_i : 32'd0;
         r_tWe    <= w_we;
      end
   end

   assign trace_valid_o = r_tValid;
   assign trace_pc_o    = r_tPc;
   assign trace_instr_o = r_tInstr;
   assign trace_rdId_o  = r_tRdId;
   assign trace_wdata_o = r_tWdata;
   assign trace_we_o    = r_tWe;
`else
   logic w_unused_trace;
   assign w_unused_trace = ^{MW_PC_i, MW_instr_i};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: clear sequence, bypassed reads, retire counting, resets, trace.
module tb_writeback_unit;
   localparam int NREGS     = 64;
   localparam int CNT_WIDTH = 64;

   logic                 clk_i = 1'b0;
   logic                 reset_i;
   logic [31:0]          MW_PC_i, MW_instr_i, MW_wbData_i;
   logic                 MW_nop_i, MW_wbEnable_i;
   logic [5:0]           MW_rdId_i, DW_rs1Id_i, DW_rs2Id_i;
   logic [31:0]          DW_rs1_o, DW_rs2_o;
   logic                 WB_busy_o;
   logic [CNT_WIDTH-1:0] WB_instret_o;
`ifdef WB_TRACE_EN
   logic                 trace_valid_o, trace_we_o;
   logic [31:0]          trace_pc_o, trace_instr_o, trace_wdata_o;
   logic [5:0]           trace_rdId_o;
`endif

   always #5 clk_i = ~clk_i;

   writeback_unit #(.NREGS(NREGS), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .MW_PC_i(MW_PC_i), .MW_instr_i(MW_instr_i), .MW_nop_i(MW_nop_i),
      .MW_rdId_i(MW_rdId_i), .MW_wbData_i(MW_wbData_i), .MW_wbEnable_i(MW_wbEnable_i),
      .DW_rs1Id_i(DW_rs1Id_i), .DW_rs2Id_i(DW_rs2Id_i),
      .DW_rs1_o(DW_rs1_o), .DW_rs2_o(DW_rs2_o), .WB_busy_o(WB_busy_o),
`ifdef WB_TRACE_EN
      .trace_valid_o(trace_valid_o), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
      .trace_rdId_o(trace_rdId_o), .trace_wdata_o(trace_wdata_o), .trace_we_o(trace_we_o),
`endif
      .WB_instret_o(WB_instret_o)
   );

   typedef struct {
      logic nop; logic wben; logic [5:0] rd; logic [31:0] data;
      logic [5:0] rs1; logic [5:0] rs2; logic [31:0] e1; logic [31:0] e2;
   } vec_t;
   typedef struct { logic [31:0] e1; logic [31:0] e2; logic [63:0] ecnt; } exp_t;

   exp_t        sb[$];
   vec_t        tbl[11];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [63:0] m_instret = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One pipeline cycle: drive, queue the expected outputs, clock, pop and compare.
   task automatic drive(input string tag, input logic nop, input logic wben,
                        input logic [5:0] rd, input logic [31:0] data,
                        input logic [5:0] rs1, input logic [5:0] rs2,
                        input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      MW_nop_i = nop; MW_wbEnable_i = wben; MW_rdId_i = rd; MW_wbData_i = data;
      DW_rs1Id_i = rs1; DW_rs2Id_i = rs2;
      if (!nop) m_instret = m_instret + 64'd1;
      e.e1 = e1; e.e2 = e2; e.ecnt = m_instret;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk({tag, ".rs1"}, DW_rs1_o, e.e1);
      chk({tag, ".rs2"}, DW_rs2_o, e.e2);
      chk({tag, ".instret"}, WB_instret_o, e.ecnt);
      MW_nop_i = 1'b1; MW_wbEnable_i = 1'b0;
   endtask

   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      chk({tag, ".busy_start"}, WB_busy_o, 1);
      while (WB_busy_o === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, ".busy_cycles"}, n, 64);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          nop   wben  rd     data          rs1    rs2    e1            e2
      tbl[0]  = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 6'd0,  6'd0,  32'h0,        32'h0};
      tbl[1]  = '{1'b0, 1'b1, 6'd0,  32'h00001234, 6'd5,  6'd0,  32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd0,  6'd5,  32'h0,        32'hDEADBEEF};
      tbl[3]  = '{1'b0, 1'b1, 6'd40, 32'hA5A5A5A5, 6'd40, 6'd40, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[4]  = '{1'b1, 1'b1, 6'd40, 32'h11111111, 6'd40, 6'd40, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[5]  = '{1'b0, 1'b0, 6'd40, 32'h22222222, 6'd40, 6'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
      tbl[6]  = '{1'b0, 1'b1, 6'd32, 32'hCAFEF00D, 6'd32, 6'd63, 32'hCAFEF00D, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 6'd63, 32'h0BADC0DE, 6'd32, 6'd63, 32'hCAFEF00D, 32'h0BADC0DE};
      tbl[8]  = '{1'b0, 1'b1, 6'd5,  32'h00000005, 6'd5,  6'd40, 32'h00000005, 32'hA5A5A5A5};
      tbl[9]  = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd63, 6'd5,  32'h0BADC0DE, 32'h00000005};
      tbl[10] = '{1'b1, 1'b0, 6'd0,  32'h0,        6'd15, 6'd1,  32'h00000EEE, 32'h0};

      MW_PC_i = '0; MW_instr_i = '0; MW_nop_i = 1'b1; MW_wbEnable_i = 1'b0;
      MW_rdId_i = '0; MW_wbData_i = '0; DW_rs1Id_i = '0; DW_rs2Id_i = '0;

      // Reset state and the full clear sequence.
      reset_i = 1'b1;
      #1;
      chk("reset.busy", WB_busy_o, 1);
      chk("reset.rs1", DW_rs1_o, 0);
      chk("reset.rs2", DW_rs2_o, 0);
      chk("reset.instret", WB_instret_o, 0);
      tick(); tick();
      reset_i = 1'b0;
      wait_clear("clr1");
      for (int i = 0; i < 32; i++)
         drive("clr_read", 1'b1, 1'b0, 6'd0, 32'h0, 6'(i), 6'(i + 32), 32'h0, 32'h0);

      // 10 retires (3 without writeback) interleaved with 5 bubbles.
      for (int i = 0; i < 15; i++)
         drive("retire", (i % 3 == 1), !(i == 0 || i == 5 || i == 9), 6'(i + 1),
               32'(i * 32'h111), 6'd0, 6'd0, 32'h0, 32'h0);
      chk("instret_10", WB_instret_o, 10);

      for (int i = 0; i < 11; i++)
         drive($sformatf("vec%0d", i), tbl[i].nop, tbl[i].wben, tbl[i].rd, tbl[i].data,
               tbl[i].rs1, tbl[i].rs2, tbl[i].e1, tbl[i].e2);

      // Counter wrap from all-ones.
      force dut.r_instret = '1;
      #1;
      release dut.r_instret;
      chk("instret_forced", WB_instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
      m_instret = '1;
      drive("wrap", 1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 32'h0, 32'h0);
      chk("instret_wrap", WB_instret_o, 0);

      // Async reset 30 entries into CLEAR.
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("midclr.idx", dut.r_clrIdx, 30);
      #2;
      reset_i = 1'b1;
      #1;
      chk("midclr.busy", WB_busy_o, 1);
      chk("midclr.idx0", dut.r_clrIdx, 0);
      tick();
      reset_i = 1'b0;
      wait_clear("clr2");
      m_instret = '0;

      // Run 100 cycles with a live register, then async reset in RUN.
      drive("run_wr", 1'b0, 1'b1, 6'd7, 32'h77, 6'd7, 6'd7, 32'h77, 32'h77);
      for (int i = 0; i < 99; i++)
         drive("run", 1'b0, 1'b0, 6'd0, 32'h0, 6'd7, 6'd0, 32'h77, 32'h0);
      chk("run.instret", WB_instret_o, 100);
      #2;
      reset_i = 1'b1;
      #1;
      chk("runrst.busy", WB_busy_o, 1);
      chk("runrst.rs1", DW_rs1_o, 0);
      chk("runrst.instret", WB_instret_o, 0);
      tick();
      reset_i = 1'b0;
      m_instret = '0;
      wait_clear("clr3");
      drive("after_rst", 1'b1, 1'b0, 6'd0, 32'h0, 6'd7, 6'd7, 32'h0, 32'h0);

`ifdef WB_TRACE_EN
      MW_PC_i = 32'h100; MW_instr_i = 32'h00A00293;
      drive("trace", 1'b0, 1'b1, 6'd5, 32'd10, 6'd0, 6'd0, 32'h0, 32'h0);
      chk("trace.valid", trace_valid_o, 1);
      chk("trace.pc", trace_pc_o, 32'h100);
      chk("trace.instr", trace_instr_o, 32'h00A00293);
      chk("trace.rd", trace_rdId_o, 5);
      chk("trace.wdata", trace_wdata_o, 10);
      chk("trace.we", trace_we_o, 1);
      drive("trace_bub", 1'b1, 1'b0, 6'd0, 32'h0, 6'd5, 6'd0, 32'd10, 32'h0);
      chk("trace.bubble", trace_valid_o, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
